// File: rtl/bist_pkg.sv
// Shared BIST definitions: FSM state encodings and default widths used by the
// pattern generator and the response checker.
package bist_pkg;

  localparam int unsigned BIST_DATA_W = 8;
  localparam int unsigned BIST_ADDR_W = 8;
  localparam int unsigned BIST_CNT_W  = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } bist_state_e;

endpackage

// File: rtl/bist_cmp_stage.sv
// Registered compare stage: masked XOR of expected vs read data, mismatch
// reduction and the address/diff/last tag of the compare. Mask input exists
// only when BIST_CMP_MASK_EN is defined.
module bist_cmp_stage
  import bist_pkg::*;
#(
  parameter int unsigned DATA_W = BIST_DATA_W,
  parameter int unsigned ADDR_W = BIST_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic              last,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_et,
`ifdef BIST_CMP_MASK_EN
  input  logic [DATA_W-1:0] data_mask,
`endif
  input  logic [DATA_W-1:0] data_read,
  output logic              cmp_valid,
  output logic              cmp_mis,
  output logic              cmp_last,
  output logic [DATA_W-1:0] cmp_diff,
  output logic [ADDR_W-1:0] cmp_addr
);

  logic [DATA_W-1:0] diff;

`ifdef BIST_CMP_MASK_EN
  assign diff = (data_et ^ data_read) & ~data_mask;
`else
  assign diff = data_et ^ data_read;
`endif

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cmp_valid <= 1'b0;
      cmp_mis   <= 1'b0;
      cmp_last  <= 1'b0;
      cmp_diff  <= '0;
      cmp_addr  <= '0;
    end else begin
      cmp_valid <= en;
      cmp_mis   <= en & (|diff);
      cmp_last  <= en & last;
      if (en) begin
        cmp_diff <= diff;
        cmp_addr <= addr;
      end
    end
  end

endmodule

// File: rtl/bist_resp_checker.sv
// BIST response checker: pass FSM, saturating error counter and first-failure
// capture fed by a one-stage compare pipeline. Optional BIST_CMP_MASK_EN adds data_mask.
module bist_resp_checker
  import bist_pkg::*;
#(
  parameter int unsigned DATA_W = BIST_DATA_W,
  parameter int unsigned ADDR_W = BIST_ADDR_W,
  parameter int unsigned CNT_W  = BIST_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              read_en,
  input  logic              last,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_et,
`ifdef BIST_CMP_MASK_EN
  input  logic [DATA_W-1:0] data_mask,
`endif
  input  logic [DATA_W-1:0] data_read,
  output logic              error,
  output logic              fail,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [ADDR_W-1:0] first_addr,
  output logic [DATA_W-1:0] first_diff,
  output logic              busy,
  output logic              done
);

  bist_state_e state_q, state_d;

  logic              cmp_en;
  logic              cmp_valid;
  logic              cmp_mis;
  logic              cmp_last;
  logic [DATA_W-1:0] cmp_diff;
  logic [ADDR_W-1:0] cmp_addr;
  logic              last_pend;

  logic              error_q;
  logic              fail_q;
  logic [CNT_W-1:0]  err_cnt_q;
  logic [ADDR_W-1:0] first_addr_q;
  logic [DATA_W-1:0] first_diff_q;

  // Once the final read is in the pipe, later reads belong to no pass.
  assign last_pend = cmp_valid & cmp_last;
  assign cmp_en    = (state_q == StRun) & read_en & ~start & ~last_pend;

  bist_cmp_stage #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_cmp (
    .clk       (clk),
    .rst       (rst),
    .clr       (start),
    .en        (cmp_en),
    .last      (last),
    .addr      (addr),
    .data_et   (data_et),
`ifdef BIST_CMP_MASK_EN
    .data_mask (data_mask),
`endif
    .data_read (data_read),
    .cmp_valid (cmp_valid),
    .cmp_mis   (cmp_mis),
    .cmp_last  (cmp_last),
    .cmp_diff  (cmp_diff),
    .cmp_addr  (cmp_addr)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StRun;
      StRun: begin
        if (start)          state_d = StRun;
        else if (last_pend) state_d = StDone;
      end
      StDone: if (start) state_d = StRun;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst || start) begin
      error_q      <= 1'b0;
      fail_q       <= 1'b0;
      err_cnt_q    <= '0;
      first_addr_q <= '0;
      first_diff_q <= '0;
    end else begin
      error_q <= cmp_valid & cmp_mis;
      if (cmp_valid && cmp_mis) begin
        fail_q <= 1'b1;
        if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + CNT_W'(1);
        if (!fail_q) begin
          first_addr_q <= cmp_addr;
          first_diff_q <= cmp_diff;
        end
      end
    end
  end

  assign error      = error_q;
  assign fail       = fail_q;
  assign err_cnt    = err_cnt_q;
  assign first_addr = first_addr_q;
  assign first_diff = first_diff_q;
  assign busy       = (state_q == StRun);
  assign done       = (state_q == StDone);

endmodule
